// File: rtl/alu_issue_pkg.sv
// Shared definitions for the alu_issue pipeline: ALU opcodes and default widths.
package alu_issue_pkg;

    localparam int DATA_WIDTH_DEF   = 32;
    localparam int ADDR_WIDTH_DEF   = 5;
    localparam int RETIRE_CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file with two combinational read ports and a merged writeback/load write port.
// Entry 0 is hardwired to zero; a writeback beats a load to the same entry.
module alu_regfile
    import alu_issue_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF,
    parameter int addr_width = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [addr_width-1:0] rs1_addr_i,
    input  logic [addr_width-1:0] rs2_addr_i,
    output logic [data_width-1:0] rs1_data_o,
    output logic [data_width-1:0] rs2_data_o,
    input  logic                  wb_en_i,
    input  logic [addr_width-1:0] wb_addr_i,
    input  logic [data_width-1:0] wb_data_i,
    input  logic                  ld_en_i,
    input  logic [addr_width-1:0] ld_addr_i,
    input  logic [data_width-1:0] ld_data_i
);

    localparam int DEPTH = 2 ** addr_width;

    logic [data_width-1:0] mem_q [DEPTH];

    // Storage update: per-entry merge of writeback and load, entry 0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {data_width{1'b0}};
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wb_en_i && (wb_addr_i == addr_width'(i))) begin
                    mem_q[i] <= wb_data_i;
                end else if (ld_en_i && (ld_addr_i == addr_width'(i))) begin
                    mem_q[i] <= ld_data_i;
                end else begin
                    mem_q[i] <= mem_q[i];
                end
            end
        end
    end

    assign rs1_data_o = (rs1_addr_i == {addr_width{1'b0}}) ? {data_width{1'b0}} : mem_q[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == {addr_width{1'b0}}) ? {data_width{1'b0}} : mem_q[rs2_addr_i];

endmodule

// File: rtl/alu_issue.sv
// Two-stage (E, W) issue pipeline around an external combinational ALU, with
// forwarding of the advancing E result into newly accepted operands.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF,
    parameter int addr_width = ADDR_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  in_op,
    input  logic [addr_width-1:0]       in_rd,
    input  logic [addr_width-1:0]       in_rs1,
    input  logic [addr_width-1:0]       in_rs2,
    input  logic                        load_en,
    input  logic [addr_width-1:0]       load_addr,
    input  logic [data_width-1:0]       load_data,
    output logic [data_width-1:0]       alu_a,
    output logic [data_width-1:0]       alu_b,
    output logic [1:0]                  alu_s,
    input  logic [data_width-1:0]       alu_c,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [addr_width-1:0]       out_rd,
    output logic [data_width-1:0]       out_data,
    output logic [RETIRE_CNT_WIDTH-1:0] retire_cnt
);

    logic                        e_valid_q, e_valid_d;
    logic [data_width-1:0]       e_a_q, e_a_d;
    logic [data_width-1:0]       e_b_q, e_b_d;
    alu_op_e                     e_op_q, e_op_d;
    logic [addr_width-1:0]       e_rd_q, e_rd_d;
    logic                        w_valid_q, w_valid_d;
    logic [addr_width-1:0]       w_rd_q, w_rd_d;
    logic [data_width-1:0]       w_data_q, w_data_d;
    logic [RETIRE_CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

    logic                        e_adv_s;
    logic                        accept_s;
    logic [data_width-1:0]       rf_rd1_s, rf_rd2_s;

    function automatic logic fwd_hit(input logic adv, input logic [addr_width-1:0] e_rd,
                                     input logic [addr_width-1:0] rs);
        return adv && (e_rd != {addr_width{1'b0}}) && (e_rd == rs);
    endfunction

    assign e_adv_s  = e_valid_q & (~w_valid_q | out_ready);
    assign in_ready = ~load_en & (~e_valid_q | e_adv_s);
    assign accept_s = in_valid & in_ready;

    alu_regfile #(
        .data_width (data_width),
        .addr_width (addr_width)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_addr_i (in_rs1),
        .rs2_addr_i (in_rs2),
        .rs1_data_o (rf_rd1_s),
        .rs2_data_o (rf_rd2_s),
        .wb_en_i    (e_adv_s),
        .wb_addr_i  (e_rd_q),
        .wb_data_i  (alu_c),
        .ld_en_i    (load_en),
        .ld_addr_i  (load_addr),
        .ld_data_i  (load_data)
    );

    // Next-state for E, W and the retire counter
    always_comb begin
        e_valid_d    = e_valid_q;
        e_a_d        = e_a_q;
        e_b_d        = e_b_q;
        e_op_d       = e_op_q;
        e_rd_d       = e_rd_q;
        w_valid_d    = w_valid_q;
        w_rd_d       = w_rd_q;
        w_data_d     = w_data_q;
        retire_cnt_d = retire_cnt_q;

        if (accept_s) begin
            e_valid_d = 1'b1;
            e_a_d     = fwd_hit(e_adv_s, e_rd_q, in_rs1) ? alu_c : rf_rd1_s;
            e_b_d     = fwd_hit(e_adv_s, e_rd_q, in_rs2) ? alu_c : rf_rd2_s;
            e_op_d    = alu_op_e'(in_op);
            e_rd_d    = in_rd;
        end else if (e_adv_s) begin
            e_valid_d = 1'b0;
        end else begin
            e_valid_d = e_valid_q;
        end

        if (e_adv_s) begin
            w_valid_d    = 1'b1;
            w_rd_d       = e_rd_q;
            w_data_d     = alu_c;
            retire_cnt_d = retire_cnt_q + 32'd1;
        end else if (w_valid_q && out_ready) begin
            w_valid_d = 1'b0;
        end else begin
            w_valid_d = w_valid_q;
        end
    end

    // Pipeline and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid_q    <= 1'b0;
            e_a_q        <= {data_width{1'b0}};
            e_b_q        <= {data_width{1'b0}};
            e_op_q       <= OP_ADD;
            e_rd_q       <= {addr_width{1'b0}};
            w_valid_q    <= 1'b0;
            w_rd_q       <= {addr_width{1'b0}};
            w_data_q     <= {data_width{1'b0}};
            retire_cnt_q <= {RETIRE_CNT_WIDTH{1'b0}};
        end else begin
            e_valid_q    <= e_valid_d;
            e_a_q        <= e_a_d;
            e_b_q        <= e_b_d;
            e_op_q       <= e_op_d;
            e_rd_q       <= e_rd_d;
            w_valid_q    <= w_valid_d;
            w_rd_q       <= w_rd_d;
            w_data_q     <= w_data_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign alu_a      = e_a_q;
    assign alu_b      = e_b_q;
    assign alu_s      = e_op_q;
    assign out_valid  = w_valid_q;
    assign out_rd     = w_rd_q;
    assign out_data   = w_data_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: program-order architectural model plus occupancy-based timing,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_issue;
    import alu_issue_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, load_en, out_valid, out_ready;
    logic [1:0]    in_op, alu_s;
    logic [AW-1:0] in_rd, in_rs1, in_rs2, load_addr, out_rd;
    logic [DW-1:0] load_data, alu_a, alu_b, alu_c, out_data;
    logic [31:0]   retire_cnt;

    alu_issue #(.data_width(DW), .addr_width(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_s(alu_s), .alu_c(alu_c), .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU
    always_comb begin
        case (alu_s)
            2'b00:   alu_c = alu_a + alu_b;
            2'b01:   alu_c = alu_a - alu_b;
            2'b10:   alu_c = alu_a & alu_b;
            default: alu_c = alu_a | alu_b;
        endcase
    end

    typedef struct {
        logic [AW-1:0] rd;
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
    } item_t;

    item_t         q[$];           // accepted, not yet handed to the consumer (oldest first)
    logic [DW-1:0] p_rf [32];      // architectural registers in program order
    int            acc_total;
    bit            acc_last;
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic logic [DW-1:0] calc(input logic [1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) p_rf[i] = '0;
        acc_total = 0;
        acc_last  = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, then commit model at the rising edge
    task automatic cycle();
        int            n, w_occ;
        bit            in_e, exp_ready, acc, hs, ld_ok;
        item_t         it;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        @(negedge clk);
        n     = q.size();
        in_e  = (n == 2) || (n == 1 && acc_last);
        w_occ = n - int'(in_e);
        exp_ready = !load_en && (!in_e || w_occ == 0 || out_ready);
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(w_occ > 0));
        chk("retire_cnt", 64'(retire_cnt), 64'(acc_total - int'(in_e)));
        if (w_occ > 0) begin
            chk("out_rd", 64'(out_rd), 64'(q[0].rd));
            chk("out_data", 64'(out_data), 64'(q[0].res));
        end
        if (in_e) begin
            chk("alu_s", 64'(alu_s), 64'(q[n-1].op));
            chk("alu_a", 64'(alu_a), 64'(q[n-1].a));
            chk("alu_b", 64'(alu_b), 64'(q[n-1].b));
        end
        acc   = in_valid && exp_ready;
        hs    = (w_occ > 0) && out_ready;
        la    = load_addr;
        ld    = load_data;
        ld_ok = load_en && (la != '0) && !(in_e && q[n-1].rd == la);
        if (acc) begin
            it.rd  = in_rd;
            it.op  = in_op;
            it.a   = p_rf[in_rs1];
            it.b   = p_rf[in_rs2];
            it.res = calc(in_op, it.a, it.b);
        end
        @(posedge clk);
        if (ld_ok) p_rf[la] = ld;
        if (hs) void'(q.pop_front());
        if (acc) begin
            q.push_back(it);
            if (it.rd != '0) p_rf[it.rd] = it.res;
            acc_total++;
        end
        acc_last = acc;
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        cycle();
        load_en = 1'b0;
    endtask

    item_t stall_list [3];
    int    base, guard;

    initial begin
        in_valid = 1'b0; in_op = 2'd0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0; out_ready = 1'b1;
        model_reset();
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_s", 64'(alu_s), 64'd0);
        chk("rst_retire", 64'(retire_cnt), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Basic add and two-edge latency
        load(5'd1, 32'd5);
        load(5'd2, 32'd3);
        issue(OP_ADD, 5'd3, 5'd1, 5'd2);
        chk("lat_not_yet", 64'(out_valid), 64'd0);
        cycle();
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_rd", 64'(out_rd), 64'd3);
        chk("add_data", 64'(out_data), 64'd8);
        chk("add_retire", 64'(retire_cnt), 64'd1);
        cycle();

        // Back-to-back with forwarding
        in_valid = 1'b1; in_op = OP_ADD; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2;
        cycle();
        in_op = OP_SUB; in_rd = 5'd4; in_rs1 = 5'd3; in_rs2 = 5'd1;
        cycle();
        in_valid = 1'b0;
        chk("fwd_first", 64'(out_data), 64'd8);
        cycle();
        chk("fwd_second_rd", 64'(out_rd), 64'd4);
        chk("fwd_second", 64'(out_data), 64'd3);
        repeat (2) cycle();

        // Backpressure: three instructions, consumer stalled
        stall_list[0].op = OP_OR;  stall_list[0].rd = 5'd6; stall_list[0].a = 32'd1; stall_list[0].b = 32'd2;
        stall_list[1].op = OP_AND; stall_list[1].rd = 5'd7; stall_list[1].a = 32'd1; stall_list[1].b = 32'd2;
        stall_list[2].op = OP_ADD; stall_list[2].rd = 5'd8; stall_list[2].a = 32'd6; stall_list[2].b = 32'd7;
        out_ready = 1'b0;
        base = acc_total;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_op = stall_list[k].op; in_rd = stall_list[k].rd;
            in_rs1 = AW'(stall_list[k].a); in_rs2 = AW'(stall_list[k].b);
            if (k == 2) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
            end
            cycle();
        end
        cycle();
        chk("stall_hold_rd", 64'(out_rd), 64'd6);
        chk("stall_hold_data", 64'(out_data), 64'd7);
        out_ready = 1'b1;
        guard = 0;
        while (acc_total < base + 3 && guard < 20) begin
            cycle();
            guard++;
        end
        chk("stall_all_accepted", 64'(guard < 20), 64'd1);
        in_valid = 1'b0;
        repeat (3) cycle();

        // Register zero
        issue(OP_OR, 5'd0, 5'd1, 5'd2);
        issue(OP_ADD, 5'd5, 5'd0, 5'd0);
        chk("r0_write_data", 64'(out_data), 64'd7);
        cycle();
        chk("r0_read_rd", 64'(out_rd), 64'd5);
        chk("r0_read_data", 64'(out_data), 64'd0);
        repeat (2) cycle();

        // Load colliding with writeback: writeback wins
        issue(OP_ADD, 5'd3, 5'd1, 5'd2);
        load_en = 1'b1; load_addr = 5'd3; load_data = 32'hFFFF_FFFF;
        #1 chk("load_blocks_ready", 64'(in_ready), 64'd0);
        cycle();
        load_en = 1'b0;
        cycle();
        issue(OP_OR, 5'd9, 5'd3, 5'd0);
        cycle();
        chk("wb_beats_load", 64'(out_data), 64'd8);
        repeat (2) cycle();

        // Randomized traffic
        for (int i = 1; i < 32; i++) load(AW'(i), $urandom);
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_op     = 2'($urandom_range(3));
            in_rd     = AW'($urandom_range(31));
            in_rs1    = AW'($urandom_range(31));
            in_rs2    = AW'($urandom_range(31));
            load_en   = ($urandom_range(9) == 0);
            load_addr = AW'($urandom_range(31));
            load_data = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
            out_ready = ($urandom_range(3) != 0);
            cycle();
        end
        in_valid = 1'b0; load_en = 1'b0; out_ready = 1'b1;
        repeat (4) cycle();

        // Reset with two instructions in flight
        out_ready = 1'b0;
        issue(OP_ADD, 5'd11, 5'd1, 5'd2);
        issue(OP_SUB, 5'd12, 5'd1, 5'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_retire", 64'(retire_cnt), 64'd0);
        chk("mid_rst_alu_a", 64'(alu_a), 64'd0);
        model_reset();
        #17 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(OP_ADD, 5'd10, 5'd1, 5'd2);
        cycle();
        chk("post_rst_rf_clear", 64'(out_data), 64'd0);
        chk("post_rst_retire", 64'(retire_cnt), 64'd1);
        issue(OP_OR, 5'd13, 5'd11, 5'd12);
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
